// File: rtl/piso_pkg.sv
// Shared types and frame-length helper for the PISO serializer and its matching deserializer.
// Frame length grows by one parity bit when PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Downstream deserializers call this so both ends agree on the frame length.
  function automatic int unsigned piso_frame_len(input int unsigned width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Up-counter with synchronous clear and enable; saturates at LAST and flags it.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned LAST = 3,
  parameter int unsigned CW   = $clog2(LAST + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  assign last = (count == LAST_C);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, MSB first, valid/ready load with gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done
);

  localparam int unsigned FRAME_LEN = piso_frame_len(WIDTH);
  localparam int unsigned CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             last, cnt_clr, cnt_en, accept;
  logic             sout_d, valid_d, done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  piso_bit_counter #(
    .LAST (FRAME_LEN - 1),
    .CW   (CW)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .last  (last)
  );

  assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && last);
  assign accept     = load_valid && load_ready;

  // Outputs are computed from the next-cycle state so they can be registered.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      shift_d = load_data;
      cnt_clr = 1'b1;
      cnt_d   = '0;
`ifdef PISO_PARITY_EN
      parity_d = ^load_data;
`endif
    end else if (state_q == SHIFT) begin
      if (last) begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        cnt_d   = '0;
      end else begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_en  = 1'b1;
        cnt_d   = cnt + CW'(1);
      end
    end
    valid_d = (state_d == SHIFT);
    done_d  = valid_d && (cnt_d == LAST_CNT);
    sout_d  = valid_d && shift_d[WIDTH-1];
`ifdef PISO_PARITY_EN
    if (valid_d && (cnt_d == CW'(WIDTH))) begin
      sout_d = parity_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      sout       <= sout_d;
      sout_valid <= valid_d;
      frame_done <= done_d;
`ifdef PISO_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed vector table plus randomized run against a bit-queue model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic         rst;
    logic         vld;
    logic [W-1:0] data;
    logic         rdy;
    logic         so;
    logic         sv;
    logic         fd;
    logic         sipo_chk;
    logic [W-1:0] sipo;
  } vec_t;

  typedef struct {
    logic b;
    logic d;
  } bit_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         sout;
  logic         sout_valid;
  logic         frame_done;
  logic [W-1:0] sipo;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  bit_t model_q[$];

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream 4-bit SIPO.
  always @(posedge clk) begin
    if (rst) sipo <= '0;
    else if (sout_valid) sipo <= {sipo[W-2:0], sout};
  end

  task automatic add(input logic r, input logic v, input logic [W-1:0] d,
                     input logic er, input logic es, input logic ev, input logic ed,
                     input logic sc, input logic [W-1:0] sp);
    vec_t t;
    t.rst = r; t.vld = v; t.data = d; t.rdy = er; t.so = es; t.sv = ev; t.fd = ed;
    t.sipo_chk = sc; t.sipo = sp;
    vecs.push_back(t);
  endtask

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic v, input logic [W-1:0] d);
    rst = r;
    load_valid = v;
    load_data = d;
  endtask

  task automatic check_cycle(input string tag, input logic er, input logic es, input logic ev, input logic ed);
    check_output({tag, " load_ready"}, W'(load_ready), W'(er));
    check_output({tag, " sout"}, W'(sout), W'(es));
    check_output({tag, " sout_valid"}, W'(sout_valid), W'(ed ? 1'b1 : ev));
    check_output({tag, " frame_done"}, W'(frame_done), W'(ed));
  endtask

  initial begin
`ifdef PISO_PARITY_EN
    // 0111 then 0110 with parity 1 and 0
    add(0,1,4'h7, 1,0,0,0, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 1,1,1,1, 0,0);
    add(0,1,4'h6, 1,0,0,0, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 1,0,1,1, 0,0);
    add(0,0,4'h0, 1,0,0,0, 0,0);
`else
    // basic load of 1011
    add(0,1,4'hB, 1,0,0,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 1,1,1,1, 0,0);
    add(0,0,4'h0, 1,0,0,0, 1,4'hB);
    // back-to-back A then 5
    add(0,1,4'hA, 1,0,0,0, 0,0);
    add(0,1,4'hA, 0,1,1,0, 0,0);
    add(0,1,4'hA, 0,0,1,0, 0,0);
    add(0,1,4'hA, 0,1,1,0, 0,0);
    add(0,1,4'h5, 1,0,1,1, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 1,1,1,1, 0,0);
    add(0,0,4'h0, 1,0,0,0, 1,4'h5);
    // busy stall: F presented while C is shifting
    add(0,1,4'hC, 1,0,0,0, 0,0);
    add(0,1,4'hF, 0,1,1,0, 0,0);
    add(0,1,4'hF, 0,1,1,0, 0,0);
    add(0,1,4'hF, 0,0,1,0, 0,0);
    add(0,1,4'hF, 1,0,1,1, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 1,1,1,1, 0,0);
    add(0,0,4'h0, 1,0,0,0, 1,4'hF);
    // reset on the 2nd bit of C, then load 3
    add(0,1,4'hC, 1,0,0,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(1,1,4'hF, 0,1,1,0, 0,0);
    add(0,1,4'h3, 1,0,0,0, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 0,0,1,0, 0,0);
    add(0,0,4'h0, 0,1,1,0, 0,0);
    add(0,0,4'h0, 1,1,1,1, 0,0);
    add(0,0,4'h0, 1,0,0,0, 1,4'h3);
`endif
    // handshake coincident with reset is dropped
    add(1,1,4'hA, 1,0,0,0, 0,0);
    add(0,0,4'h0, 1,0,0,0, 0,0);

    apply_stimulus(1'b1, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, '0);
    check_cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].vld, vecs[i].data);
      check_cycle($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].so, vecs[i].sv, vecs[i].fd);
      if (vecs[i].sipo_chk) check_output($sformatf("vec%0d sipo", i), sipo, vecs[i].sipo);
      @(negedge clk);
    end

    // randomized run: the model holds the bits still to appear on sout, front = current cycle
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      logic         r, v, acc;
      logic [W-1:0] d;
      bit_t         cur;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 2) != 0);
      d = W'($urandom);
      apply_stimulus(r, v, d);
      cur.b = 1'b0;
      cur.d = 1'b0;
      if (model_q.size() > 0) cur = model_q[0];
      check_cycle($sformatf("rand%0d", c), model_q.size() <= 1, cur.b, model_q.size() > 0, cur.d);
      if (r) begin
        model_q.delete();
      end else begin
        acc = v && (model_q.size() <= 1);
        if (model_q.size() > 0) void'(model_q.pop_front());
        if (acc) begin
          for (int i = W - 1; i >= 0; i--) model_q.push_back('{b: d[i], d: (i == 0) && !PAR});
          if (PAR) model_q.push_back('{b: ^d, d: 1'b1});
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
